mult_ctrl: RTL and testbench
============================

// Module: mult_ctrl
// PURPOSE
//   Shift-and-add unsigned multiplier control and datapath. Drives the
//   external 4-bit iteration down-counter through cnt_load/cnt_count and
//   reads its value back on cnt_out to decide when to stop. Sits between the
//   start/operand source and the down-counter. Produces a 2*WIDTH-bit product
//   with a start/busy/done handshake.
// PARAMETERS
//   WIDTH     4   operand width in bits; range 1..15; product is 2*WIDTH bits
//   CNT_INIT  4   value the counter loads; must equal WIDTH
//   WDOG_MAX  8   watchdog limit, in CALC cycles (used only with MULT_WDOG_EN)
// PORTS
//   clk        in   1        clock, rising edge
//   clear      in   1        asynchronous reset, active-low (0 = reset)
//   start      in   1        request a multiply; sampled only in IDLE
//   a          in   WIDTH    multiplicand, captured on the accepting edge
//   b          in   WIDTH    multiplier, captured on the accepting edge
//   cnt_out    in   4        current value of the iteration down-counter
//   cnt_load   out  1        loads CNT_INIT into the counter on the next edge
//   cnt_count  out  1        decrements the counter on the next edge (if != 0)
//   busy       out  1        1 in every state except IDLE
//   done       out  1        one-cycle pulse: product is valid
//   product    out  2*WIDTH  result; held from DONE until the next accept
//   err        out  1        watchdog error flag (tied 0 without MULT_WDOG_EN)
// BEHAVIOUR
//   - Reset (clear=0, asynchronous): state=IDLE; M, acc, product, err = 0;
//     cnt_load, cnt_count, busy, done = 0. The counter has no reset of its own,
//     so every operation reloads it in LOAD.
//   - Moore FSM: IDLE -> LOAD -> CALC -> DONE -> IDLE.
//   - IDLE: if start=1 at an edge, M<=a; acc<={1'b0, WIDTH'b0, b}; go LOAD.
//   - LOAD: cnt_load=1 for one cycle; go CALC. Counter reads CNT_INIT next.
//   - CALC, cnt_out!=0: cnt_count=1. If acc[0]=1, {C,P}<=P+M with carry,
//     then shift {C,P,Q} right by 1. Both happen on the same edge.
//   - CALC, cnt_out==0: no count, no shift; product<=acc[2*WIDTH-1:0];
//     go DONE.
//   - DONE: done=1 for one cycle; go IDLE. product is held until the next
//     start is accepted.
//   - Latency: start is sampled at edge E0. The four iterations complete at
//     edges E2..E5. done is high in the cycle after E6. The next start can be
//     accepted at E7.
//   - start while busy=1 is ignored; it is neither queued nor able to
//     corrupt operands.
//   - a and b may change after the accepting edge without effect.
//   - acc is 2*WIDTH+1 bits wide, so the carry is never lost. Maximum result
//     is (2^WIDTH-1)^2, for example 225 when WIDTH=4.
//   - If cnt_out==0 on the first CALC cycle (counter fault), the block goes
//     to DONE with the unshifted acc as product.
//   - Reset during any state aborts immediately. The counter value is left
//     stale and is reloaded by the next LOAD.
// CONFIGURATION
//   MULT_WDOG_EN defined:
//     - A 4-bit watchdog counter clears in LOAD and increments each CALC cycle.
//     - If it reaches WDOG_MAX before cnt_out==0, the FSM goes to DONE with
//       product=0 and err=1.
//     - err holds until the next accept or reset.
//   MULT_WDOG_EN undefined:
//     - The watchdog logic is not built and err is tied to 0.
//     - A stuck counter leaves the FSM in CALC until reset.
// TESTING
//   - Model the counter: load -> 4, count decrements down to 0.
//     a=3, b=5, start pulse -> done one cycle after E6, product=15, busy=0
//     next cycle.
//   - a=15, b=15 -> product=225 (carry path exercised); a=0, b=9 -> 0;
//     a=9, b=0 -> 0.
//   - Hold start=1 continuously -> back-to-back operations, one accept every
//     7 edges. start pulses during busy do not alter the result.
//   - Assert clear=0 while in CALC (counter=2) -> all outputs 0 immediately.
//     A following 6*7 multiply gives 42.
//   - MULT_WDOG_EN, counter held at 4 -> err=1, done pulse, product=0 after
//     WDOG_MAX CALC cycles. Without MULT_WDOG_EN, the FSM stays busy.
//   - Change a and b on the edge after the accept -> the product uses the
//     captured operands.

Source files
------------

// File: rtl/mult_ctrl_if.sv
// Operand/handshake and iteration-counter bundle for mult_ctrl.
// master = operand source plus external down-counter, slave = mult_ctrl.
interface mult_ctrl_if #(
  parameter int WIDTH = 4
);
  // Handshake: start is acted on only when busy=0 or in the done cycle.
  // a/b are captured on that edge. busy stays high until the operation
  // retires, and done pulses for one cycle when product becomes valid.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           cnt_out;
  logic                 cnt_load;
  logic                 cnt_count;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 err;
  logic [1:0]           fsm_state;

  modport master (
    output start, a, b, cnt_out,
    input  cnt_load, cnt_count, busy, done, product, err, fsm_state
  );

  modport slave (
    input  start, a, b, cnt_out,
    output cnt_load, cnt_count, busy, done, product, err, fsm_state
  );
endinterface

// File: rtl/mult_ctrl.sv
// Shift-and-add unsigned multiplier that sequences an external 4-bit down-counter.
// Optional watchdog on a stuck counter is built when MULT_WDOG_EN is defined.
module mult_ctrl #(
  parameter int WIDTH    = 4,
  parameter int CNT_INIT = 4,
  parameter int WDOG_MAX = 8
) (
  input  logic         clk,
  input  logic         clear,
  mult_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     m;
  logic [2*WIDTH:0]     acc;
  logic [WIDTH:0]       sum;
  logic                 cnt_load;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // acc holds {C, P, Q}; C is always zero before an add because the previous
  // shift moved it into P.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};

`ifdef MULT_WDOG_EN
  localparam logic [3:0] WDOG_LAST = 4'(WDOG_MAX - 1);
  logic [3:0] wdog;
  logic       err;
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      m        <= '0;
      acc      <= '0;
      product  <= '0;
      cnt_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MULT_WDOG_EN
      wdog     <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE also accepts so that a held start gives one accept every 7 edges.
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.start) begin
            m        <= bus.a;
            acc      <= {1'b0, {WIDTH{1'b0}}, bus.b};
            cnt_load <= 1'b1;
            busy     <= 1'b1;
`ifdef MULT_WDOG_EN
            err      <= 1'b0;
`endif
            state    <= LOAD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        LOAD: begin
          cnt_load <= 1'b0;
`ifdef MULT_WDOG_EN
          wdog     <= '0;
`endif
          state    <= CALC;
        end
        CALC: begin
          if (bus.cnt_out == 4'd0) begin
            product <= acc[2*WIDTH-1:0];
            done    <= 1'b1;
            state   <= DONE;
          end
`ifdef MULT_WDOG_EN
          else if (wdog == WDOG_LAST) begin
            product <= '0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end
`endif
          else begin
`ifdef MULT_WDOG_EN
            wdog <= wdog + 4'd1;
`endif
            if (acc[0]) acc <= {sum, acc[WIDTH-1:0]} >> 1;
            else        acc <= acc >> 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cnt_load  = cnt_load;
  assign bus.cnt_count = (state == CALC) && (bus.cnt_out != 4'd0);
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.product   = product;
  assign bus.fsm_state = state;
`ifdef MULT_WDOG_EN
  assign bus.err       = err;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural model of the external down-counter.
module tb_mult_ctrl;

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  mult_ctrl_if #(.WIDTH(4)) bus ();

  mult_ctrl #(.WIDTH(4), .CNT_INIT(4), .WDOG_MAX(8)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counter model: no reset, load -> 4, count saturates at 0; can be frozen.
  logic [3:0] cnt = 4'd0;
  logic       frozen = 1'b0;
  logic [3:0] frz_val = 4'd0;

  always @(posedge clk) begin
    if (bus.cnt_load)                   cnt <= 4'd4;
    else if (bus.cnt_count && cnt != 0) cnt <= cnt - 4'd1;
  end
  assign bus.cnt_out = frozen ? frz_val : cnt;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Driver: presents operands with a one-cycle start pulse; returns at the
  // negedge after the accepting edge.
  task automatic issue(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges since the accept until done is seen; -1 on timeout.
  task automatic wait_done(output int cycles);
    int n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    cycles = bus.done ? n : -1;
  endtask

  task automatic test_reset;
    clear     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.product !== 8'd0) begin errors++; $display("FAIL reset_product: got %0d want 0", bus.product); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.cnt_load !== 1'b0 || bus.cnt_count !== 1'b0) begin errors++; $display("FAIL reset_cnt_ctrl: got load=%b count=%b want 0 0", bus.cnt_load, bus.cnt_count); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    issue(4'd3, 4'd5);
    checks++; if (bus.cnt_load !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_load: got load=%b busy=%b want 1 1", bus.cnt_load, bus.busy); end
    @(negedge clk);
    checks++; if (bus.cnt_load !== 1'b0 || bus.cnt_count !== 1'b1 || bus.cnt_out !== 4'd4) begin errors++; $display("FAIL basic_calc: got load=%b count=%b cnt=%0d want 0 1 4", bus.cnt_load, bus.cnt_count, bus.cnt_out); end
    wait_done(cyc);
    cyc = cyc + 1;
    checks++; if (cyc !== 7) begin errors++; $display("FAIL basic_latency: got %0d want 7", cyc); end
    checks++; if (bus.product !== 8'd15) begin errors++; $display("FAIL basic_product: got %0d want 15", bus.product); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL basic_retire: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.product !== 8'd15) begin errors++; $display("FAIL basic_hold: got %0d want 15", bus.product); end
  endtask

  task automatic test_boundaries;
    logic [3:0] va [3] = '{4'd15, 4'd0, 4'd9};
    logic [3:0] vb [3] = '{4'd15, 4'd9, 4'd0};
    logic [7:0] ve [3] = '{8'd225, 8'd0, 8'd0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i]);
      wait_done(cyc);
      checks++; if (cyc !== 7) begin errors++; $display("FAIL bound_latency_%0d: got %0d want 7", i, cyc); end
      checks++; if (bus.product !== ve[i]) begin errors++; $display("FAIL bound_product_%0d: %0d*%0d got %0d want %0d", i, va[i], vb[i], bus.product, ve[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.a = 4'd2; bus.b = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 4'd4; bus.b = 4'd5;
    repeat (6) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.product !== 8'd6) begin errors++; $display("FAIL b2b_first: got done=%b product=%0d want 1 6", bus.done, bus.product); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.cnt_load !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got busy=%b load=%b want 1 1", bus.busy, bus.cnt_load); end
    repeat (6) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.product !== 8'd20) begin errors++; $display("FAIL b2b_second: got done=%b product=%0d want 1 20", bus.done, bus.product); end
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    issue(4'd3, 4'd5);
    repeat (2) @(negedge clk);
    bus.a = 4'd15; bus.b = 4'd15; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    checks++; if (bus.product !== 8'd15) begin errors++; $display("FAIL busy_ignore_product: got %0d want 15", bus.product); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_queued: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_operand_change;
    int cyc;
    @(negedge clk);
    bus.a = 4'd11; bus.b = 4'd13; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 4'd1; bus.b = 4'd2;
    wait_done(cyc);
    checks++; if (bus.product !== 8'd143) begin errors++; $display("FAIL operand_change: got %0d want 143", bus.product); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int cyc;
    issue(4'd3, 4'd5);
    repeat (3) @(negedge clk);
    checks++; if (bus.cnt_out !== 4'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL abort_setup: got cnt=%0d busy=%b want 2 1", bus.cnt_out, bus.busy); end
    clear = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt_load !== 1'b0 || bus.cnt_count !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy=%b done=%b load=%b count=%b want 0 0 0 0", bus.busy, bus.done, bus.cnt_load, bus.cnt_count); end
    checks++; if (bus.product !== 8'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL abort_data: got product=%0d err=%b want 0 0", bus.product, bus.err); end
    @(negedge clk);
    clear = 1'b1;
    issue(4'd6, 4'd7);
    wait_done(cyc);
    checks++; if (cyc !== 7 || bus.product !== 8'd42) begin errors++; $display("FAIL abort_recover: got cycles=%0d product=%0d want 7 42", cyc, bus.product); end
    @(negedge clk);
  endtask

  task automatic test_cnt_fault;
    int cyc;
    frozen = 1'b1; frz_val = 4'd0;
    issue(4'd3, 4'd5);
    checks++; if (bus.cnt_count !== 1'b0) begin errors++; $display("FAIL fault_count: got %b want 0", bus.cnt_count); end
    wait_done(cyc);
    checks++; if (cyc !== 3 || bus.product !== 8'd5) begin errors++; $display("FAIL fault_product: got cycles=%0d product=%0d want 3 5", cyc, bus.product); end
    frozen = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stuck_counter;
    int cyc;
    frozen = 1'b1; frz_val = 4'd4;
    issue(4'd3, 4'd5);
    wait_done(cyc);
`ifdef MULT_WDOG_EN
    checks++; if (cyc !== 10) begin errors++; $display("FAIL wdog_latency: got %0d want 10", cyc); end
    checks++; if (bus.err !== 1'b1 || bus.product !== 8'd0) begin errors++; $display("FAIL wdog_result: got err=%b product=%0d want 1 0", bus.err, bus.product); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL wdog_hold: got err=%b busy=%b want 1 0", bus.err, bus.busy); end
    frozen = 1'b0;
    issue(4'd2, 4'd2);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got err=%b want 0", bus.err); end
    wait_done(cyc);
    checks++; if (bus.product !== 8'd4) begin errors++; $display("FAIL wdog_recover: got %0d want 4", bus.product); end
`else
    checks++; if (cyc !== -1 || bus.busy !== 1'b1) begin errors++; $display("FAIL stuck_busy: got cycles=%0d busy=%b want -1 1", cyc, bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL stuck_err: got %b want 0", bus.err); end
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    frozen = 1'b0;
    issue(4'd2, 4'd2);
    wait_done(cyc);
    checks++; if (bus.product !== 8'd4) begin errors++; $display("FAIL stuck_recover: got %0d want 4", bus.product); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_busy_ignore();
    test_operand_change();
    test_reset_abort();
    test_cnt_fault();
    test_stuck_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
